// File: rtl/alu_nbit_seq_if.sv
// Operand/result bundle for alu_nbit_seq.
// The master drives the operands and opcode; the slave returns the registered result and flags.
interface alu_nbit_seq_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [4:0]       opcode;
    logic             out_valid;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_hi;
    logic             carry;
    logic             zero;
    logic             neg;
    logic             ovf;
    logic             err;

    modport master (
        output in_valid, a, b, opcode,
        input  in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, err
    );

    modport slave (
        input  in_valid, a, b, opcode,
        output in_ready, out_valid, y, y_hi, carry, zero, neg, ovf, err
    );
endinterface

// File: rtl/alu_nbit_seq.sv
// Registered WIDTH-bit ALU with a valid/ready input handshake and status flags.
// Build macro ALU_MUL_EN adds the multi-cycle shift-add unsigned multiplier on opcode 21.
module alu_nbit_seq #(
    parameter int WIDTH = 8
) (
    input logic           clk,
    input logic           rst_n,
    alu_nbit_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // Returns {carry_or_borrow, signed_overflow, result} of x+y or x-y.
    function automatic logic [WIDTH+1:0] arith_f(input logic [WIDTH-1:0] x,
                                                 input logic [WIDTH-1:0] y,
                                                 input logic             sub);
        logic [WIDTH:0] ext;
        logic           v;
        if (sub) begin
            ext = {1'b0, x} - {1'b0, y};
            v   = (x[WIDTH-1] != y[WIDTH-1]) && (ext[WIDTH-1] != x[WIDTH-1]);
        end else begin
            ext = {1'b0, x} + {1'b0, y};
            v   = (x[WIDTH-1] == y[WIDTH-1]) && (ext[WIDTH-1] != x[WIDTH-1]);
        end
        return {ext[WIDTH], v, ext[WIDTH-1:0]};
    endfunction

    logic [WIDTH-1:0] res_s;
    logic             carry_s;
    logic             ovf_s;
    logic             err_s;

    logic [WIDTH-1:0] y_r;
    logic [WIDTH-1:0] y_hi_r;
    logic             carry_r;
    logic             zero_r;
    logic             neg_r;
    logic             ovf_r;
    logic             err_r;
    logic             out_valid_r;

    // Single-cycle result and flags from the live operands; unknown opcodes fall to err.
    always_comb begin
        res_s   = '0;
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        err_s   = 1'b0;
        case (bus.opcode)
            5'd0:    {carry_s, ovf_s, res_s} = arith_f(bus.a, bus.b, 1'b0);
            5'd1:    {carry_s, ovf_s, res_s} = arith_f(bus.a, bus.b, 1'b1);
            5'd2:    res_s = ~bus.a;
            5'd3:    res_s = bus.a & bus.b;
            5'd4:    res_s = bus.a | bus.b;
            5'd5:    res_s = ~(bus.a & bus.b);
            5'd6:    res_s = ~(bus.a | bus.b);
            5'd7:    res_s = bus.a ^ bus.b;
            5'd8:    res_s = ~(bus.a ^ bus.b);
            5'd9:    res_s = bus.a;
            5'd10:   res_s = '0;
            5'd11:   res_s = '1;
            5'd12:   {carry_s, ovf_s, res_s} = arith_f(bus.a, ONE, 1'b0);
            5'd13:   {carry_s, ovf_s, res_s} = arith_f(bus.a, ONE, 1'b1);
            5'd14:   {carry_s, ovf_s, res_s} = arith_f(bus.b, ONE, 1'b0);
            5'd15:   {carry_s, ovf_s, res_s} = arith_f(bus.b, ONE, 1'b1);
            5'd16: begin
                res_s   = {bus.a[WIDTH-2:0], 1'b0};
                carry_s = bus.a[WIDTH-1];
            end
            5'd17: begin
                res_s   = {1'b0, bus.a[WIDTH-1:1]};
                carry_s = bus.a[0];
            end
            5'd18: begin
                res_s   = {bus.a[WIDTH-1], bus.a[WIDTH-1:1]};
                carry_s = bus.a[0];
            end
            5'd19: begin
                res_s   = {bus.a[WIDTH-2:0], bus.a[WIDTH-1]};
                carry_s = bus.a[WIDTH-1];
            end
            5'd20: begin
                res_s   = {bus.a[0], bus.a[WIDTH-1:1]};
                carry_s = bus.a[0];
            end
            default: err_s = 1'b1;
        endcase
    end

`ifdef ALU_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_MUL  = 1'b1
    } state_t;

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [WIDTH-1:0]   mcand_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] prod_nxt_s;
    logic [WIDTH:0]     psum_s;

    // One shift-add step: low half holds the unconsumed multiplier bits, high half the partial sum.
    always_comb begin
        if (prod_r[0]) begin
            psum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + {1'b0, mcand_r};
        end else begin
            psum_s = {1'b0, prod_r[2*WIDTH-1:WIDTH]};
        end
        prod_nxt_s = {psum_s, prod_r[WIDTH-1:1]};
    end

    assign bus.in_ready = (state_r == ST_IDLE);
`else
    assign bus.in_ready = 1'b1;
`endif

    // Control state, multiplier datapath and registered result/flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            y_r         <= '0;
            y_hi_r      <= '0;
            carry_r     <= 1'b0;
            zero_r      <= 1'b0;
            neg_r       <= 1'b0;
            ovf_r       <= 1'b0;
            err_r       <= 1'b0;
            out_valid_r <= 1'b0;
`ifdef ALU_MUL_EN
            state_r     <= ST_IDLE;
            cnt_r       <= '0;
            mcand_r     <= '0;
            prod_r      <= '0;
`endif
        end else begin
            out_valid_r <= 1'b0;
`ifdef ALU_MUL_EN
            case (state_r)
                ST_IDLE: begin
                    if (bus.in_valid && (bus.opcode == 5'd21)) begin
                        state_r <= ST_MUL;
                        cnt_r   <= '0;
                        mcand_r <= bus.a;
                        prod_r  <= {{WIDTH{1'b0}}, bus.b};
                    end else if (bus.in_valid) begin
                        y_r         <= res_s;
                        y_hi_r      <= '0;
                        carry_r     <= carry_s;
                        zero_r      <= !err_s && (res_s == '0);
                        neg_r       <= res_s[WIDTH-1];
                        ovf_r       <= ovf_s;
                        err_r       <= err_s;
                        out_valid_r <= 1'b1;
                    end
                end
                ST_MUL: begin
                    prod_r <= prod_nxt_s;
                    cnt_r  <= cnt_r + CW'(1);
                    if (cnt_r == CW'(WIDTH - 1)) begin
                        state_r     <= ST_IDLE;
                        y_r         <= prod_nxt_s[WIDTH-1:0];
                        y_hi_r      <= prod_nxt_s[2*WIDTH-1:WIDTH];
                        carry_r     <= 1'b0;
                        zero_r      <= (prod_nxt_s == '0);
                        neg_r       <= prod_nxt_s[WIDTH-1];
                        ovf_r       <= 1'b0;
                        err_r       <= 1'b0;
                        out_valid_r <= 1'b1;
                    end
                end
                default: state_r <= ST_IDLE;
            endcase
`else
            if (bus.in_valid) begin
                y_r         <= res_s;
                y_hi_r      <= '0;
                carry_r     <= carry_s;
                zero_r      <= !err_s && (res_s == '0);
                neg_r       <= res_s[WIDTH-1];
                ovf_r       <= ovf_s;
                err_r       <= err_s;
                out_valid_r <= 1'b1;
            end
`endif
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.y         = y_r;
    assign bus.y_hi      = y_hi_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;
    assign bus.neg       = neg_r;
    assign bus.ovf       = ovf_r;
    assign bus.err       = err_r;
endmodule

// File: tb/tb_alu_nbit_seq.sv
// Scoreboard bench for alu_nbit_seq (WIDTH=8); expectations are queued at drive time
// and popped when out_valid is seen. Follows ALU_MUL_EN the same way the design does.
module tb_alu_nbit_seq;
    localparam int W = 8;
`ifdef ALU_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] y;
        logic [W-1:0] yhi;
        logic [4:0]   fl;   // {carry, zero, neg, ovf, err}
        int           cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ov_cnt = 0;

    alu_nbit_seq_if #(.WIDTH(W)) bus ();
    alu_nbit_seq #(.WIDTH(W)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [W-1:0] y, input logic [W-1:0] yhi, input logic [4:0] fl);
        exp_t e;
        e.y = y; e.yhi = yhi; e.fl = fl; e.cyc = 0;
        return e;
    endfunction

    // Reference model written with plain integer arithmetic.
    function automatic exp_t model(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        exp_t e;
        int ua, ub, x, y, sx, sy, r, sr, res, mask, half;
        bit c, v, arith, sub_op, illegal;
        mask = (1 << W) - 1; half = 1 << (W - 1);
        ua = int'(av); ub = int'(bv);
        x = 0; y = 0; r = 0; res = 0;
        c = 1'b0; v = 1'b0; arith = 1'b0; sub_op = 1'b0; illegal = 1'b0;
        e.yhi = '0; e.cyc = 0; e.y = '0; e.fl = '0;
        case (op)
            5'd0:  begin arith = 1'b1; x = ua; y = ub; end
            5'd1:  begin arith = 1'b1; sub_op = 1'b1; x = ua; y = ub; end
            5'd2:  res = ~ua & mask;
            5'd3:  res = ua & ub;
            5'd4:  res = ua | ub;
            5'd5:  res = ~(ua & ub) & mask;
            5'd6:  res = ~(ua | ub) & mask;
            5'd7:  res = ua ^ ub;
            5'd8:  res = ~(ua ^ ub) & mask;
            5'd9:  res = ua;
            5'd10: res = 0;
            5'd11: res = mask;
            5'd12: begin arith = 1'b1; x = ua; y = 1; end
            5'd13: begin arith = 1'b1; sub_op = 1'b1; x = ua; y = 1; end
            5'd14: begin arith = 1'b1; x = ub; y = 1; end
            5'd15: begin arith = 1'b1; sub_op = 1'b1; x = ub; y = 1; end
            5'd16: begin res = (ua << 1) & mask; c = ua[W-1]; end
            5'd17: begin res = ua >> 1; c = ua[0]; end
            5'd18: begin res = (ua >> 1) | (ua & half); c = ua[0]; end
            5'd19: begin res = ((ua << 1) & mask) | (ua >> (W - 1)); c = ua[W-1]; end
            5'd20: begin res = (ua >> 1) | ((ua & 1) << (W - 1)); c = ua[0]; end
            5'd21: begin
                if (MUL_EN) begin
                    r = ua * ub;
                    e.y = W'(r); e.yhi = W'(r >> W);
                    e.fl = {1'b0, r == 0, e.y[W-1], 1'b0, 1'b0};
                    return e;
                end else illegal = 1'b1;
            end
            default: illegal = 1'b1;
        endcase
        if (illegal) begin
            e.fl = 5'b00001;
        end else begin
            if (arith) begin
                r  = sub_op ? x - y : x + y;
                c  = sub_op ? (x < y) : (r > mask);
                sx = (x >= half) ? x - (1 << W) : x;
                sy = (y >= half) ? y - (1 << W) : y;
                sr = sub_op ? sx - sy : sx + sy;
                v  = (sr >= half) || (sr < -half);
                res = r & mask;
            end
            e.y  = W'(res);
            e.fl = {c, res == 0, e.y[W-1], v, 1'b0};
        end
        return e;
    endfunction

    // Present one op at a negedge once in_ready is seen; it is accepted at the next posedge.
    task automatic send(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv, input exp_t e);
        int n;
        n = 0;
        @(negedge clk);
        while (!bus.in_ready && n < 40) begin
            bus.in_valid = 1'b0;
            @(negedge clk);
            n++;
        end
        check_eq("in_ready_wait", 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1; bus.opcode = op; bus.a = av; bus.b = bv;
        e.cyc = cyc + 1 + ((MUL_EN && op == 5'd21) ? W : 0);
        sb.push_back(e);
    endtask

    task automatic send_m(input logic [4:0] op, input logic [W-1:0] av, input logic [W-1:0] bv);
        send(op, av, bv, model(op, av, bv));
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        #1;
        check_eq("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        #1 sb.delete();
        repeat (cycles) @(negedge clk);
        check_eq("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check_eq("rst_y", 32'(bus.y), 32'd0);
        check_eq("rst_y_hi", 32'(bus.y_hi), 32'd0);
        check_eq("rst_flags", 32'({bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("rst_in_ready", 32'(bus.in_ready), 32'd1);
    endtask

    // Monitor: every out_valid pulse must match the oldest queued expectation, on time.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.out_valid === 1'b1) begin
            ov_cnt <= ov_cnt + 1;
            if (sb.size() == 0) begin
                check_eq("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("y", 32'(bus.y), 32'(e.y));
                check_eq("y_hi", 32'(bus.y_hi), 32'(e.yhi));
                check_eq("flags_cznve", 32'({bus.carry, bus.zero, bus.neg, bus.ovf, bus.err}), 32'(e.fl));
                check_eq("latency", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int ov0;
        int lowcnt;
        logic [W-1:0] ra, rb;
        bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.opcode = '0;
        do_reset(2);

        send(5'd0,  8'hF0, 8'h20, mk(8'h10, 8'h00, 5'b10000));
        send(5'd0,  8'h7F, 8'h01, mk(8'h80, 8'h00, 5'b00110));
        send(5'd1,  8'h04, 8'h07, mk(8'hFD, 8'h00, 5'b10100));
        send(5'd1,  8'h80, 8'h01, mk(8'h7F, 8'h00, 5'b00010));
        send(5'd13, 8'h01, 8'h5A, mk(8'h00, 8'h00, 5'b01000));
        send(5'd25, 8'h33, 8'h44, mk(8'h00, 8'h00, 5'b00001));
        wait_drain();

        ov0 = ov_cnt;
        for (int op = 0; op <= 20; op++) send_m(5'(op), 8'h07, 8'h04);
        wait_drain();
        check_eq("b2b_pulses", 32'(ov_cnt - ov0), 32'd21);

        for (int i = 0; i < 30; i++) begin
            ra = W'($urandom); rb = W'($urandom);
            send_m(5'($urandom_range(0, 31)), ra, rb);
        end
        wait_drain();

        for (int i = 0; i < 3; i++) send_m(5'($urandom_range(0, 31)), W'($urandom), W'($urandom));
        do_reset(2);

`ifdef ALU_MUL_EN
        send(5'd21, 8'hFF, 8'hFF, mk(8'h01, 8'hFE, 5'b00000));
        lowcnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (!bus.in_ready) lowcnt++;
            bus.in_valid = (i < 7);
            bus.opcode = 5'd0; bus.a = W'($urandom); bus.b = W'($urandom);
        end
        check_eq("mul_ready_low", 32'(lowcnt), 32'd8);
        wait_drain();

        send_m(5'd21, 8'h12, 8'h34);
        send(5'd21, 8'h00, 8'h9C, mk(8'h00, 8'h00, 5'b01000));
        wait_drain();

        send(5'd0, 8'h7F, 8'h01, mk(8'h80, 8'h00, 5'b00110));
        send_m(5'd21, 8'h12, 8'h34);
        repeat (3) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
        end
        do_reset(2);
`else
        send(5'd21, 8'hFF, 8'hFF, mk(8'h00, 8'h00, 5'b00001));
        send(5'd0, 8'h01, 8'h01, mk(8'h02, 8'h00, 5'b00000));
        wait_drain();
        lowcnt = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!bus.in_ready) lowcnt++;
        end
        check_eq("nomul_ready_low", 32'(lowcnt), 32'd0);
`endif
        send(5'd25, 8'hAA, 8'h55, mk(8'h00, 8'h00, 5'b00001));
        send(5'd21, 8'h03, 8'h05,
             MUL_EN ? mk(8'h0F, 8'h00, 5'b00000) : mk(8'h00, 8'h00, 5'b00001));
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_nbit_seq.md
# alu_nbit_seq

Registered, parametrised-width ALU with a valid/ready input handshake, status flags and an optional multi-cycle unsigned multiplier. It keeps the 16-operation opcode set of the team's existing 4-bit combinational ALU (codes 0–15) and extends it with shifts, rotates and multiply. It sits between the datapath register file and the writeback stage, where results must be registered and flagged.

## Interface
- WIDTH, 8, operand/result width in bits (≥ 4)
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  operands/opcode present
- in_ready  out  1  block can accept; high exactly when state = IDLE
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- opcode  in  5  operation select
- out_valid  out  1  one-cycle pulse: result/flags updated this cycle
- y  out  WIDTH  result (low half for MUL)
- y_hi  out  WIDTH  high half of MUL product, 0 for all other ops
- carry  out  1  carry / borrow / shifted-out bit
- zero  out  1  result == 0 (full 2·WIDTH product for MUL)
- neg  out  1  y[WIDTH-1]
- ovf  out  1  signed overflow
- err  out  1  illegal opcode

## Operation
- Acceptance occurs on a rising edge with in_valid & in_ready. a, b and opcode are sampled only at acceptance; later changes are ignored.
- Opcodes 0–15 map as follows:
  - 0–1: a+b, a−b.
  - 2–8: ~a, a&b, a|b, ~(a&b), ~(a|b), a^b, ~(a^b).
  - 9–11: a, all-zeros, all-ones.
  - 12–15: a+1, a−1, b+1, b−1.
- Opcodes 16–20 (shift amount is always 1):
  - 16: a<<1.
  - 17: a>>1 (logical).
  - 18: arithmetic a>>1.
  - 19: rotate-left a.
  - 20: rotate-right a.
- Opcode 21 is MUL: unsigned a·b giving {y_hi,y}, computed shift-add, one partial product per cycle.
- Opcodes 22–31 are illegal: y=0, y_hi=0, all flags 0, err=1.
- All arithmetic is modulo 2^WIDTH. Flags are computed on the truncated result.
- carry:
  - Carry-out for add/inc ops.
  - Borrow (1 when minuend < subtrahend) for sub/dec ops.
  - Bit shifted or rotated out for 16–20.
  - 0 otherwise.
- ovf is the signed overflow for ops 0, 1 and 12–15, and 0 otherwise.
- err is 0 for legal opcodes.
- State machine:
  - IDLE: accept single-cycle op → stay IDLE, result registered. Accept MUL → MUL, counter=0.
  - MUL: counter increments each cycle; in_valid is ignored. When counter = WIDTH−1 → IDLE, result registered.
- y, y_hi and the flags hold their last value until the next result. out_valid is high only in the cycle after a result is registered.

## Timing
- Reset (rst_n=0 at a clock edge): state=IDLE, counter=0. y, y_hi, carry, zero, neg, ovf, err and out_valid all become 0. in_ready is 1 from the first cycle after reset.
- Single-cycle op latency is 1 clock: acceptance at edge E gives out_valid, y and flags valid after E.
- MUL latency is WIDTH clocks: out_valid is high after edge E+WIDTH. in_ready is low from after E until after E+WIDTH.
- Throughput:
  - Single-cycle ops: one per clock, back-to-back accepted.
  - MUL: in_ready is high in the same cycle as its out_valid, so a new op may be accepted then.
- Reset during MUL aborts it with no out_valid and all outputs zeroed.
- There is no output backpressure. The consumer must take the result on the out_valid pulse.

## Configuration
- Macro ALU_MUL_EN.
- Defined: opcode 21 is the multi-cycle multiplier above, including the MUL state and counter.
- Undefined: no MUL state or multiplier logic. Opcode 21 is illegal (single-cycle, y=0, y_hi=0, err=1), and in_ready is always 1 outside reset.

## Test plan
- Reset: drive rst_n=0 for 2 clocks after random activity → all outputs 0, in_ready=1 on the first cycle after release.
- WIDTH=8, ADD a=0xF0 b=0x20 → 1 clock later out_valid=1, y=0x10, carry=1, zero=0, ovf=0, err=0. ADD a=0x7F b=0x01 → y=0x80, ovf=1, neg=1.
- SUB a=0x04 b=0x07 → y=0xFD, carry=1, neg=1. SUB a=0x80 b=0x01 → y=0x7F, ovf=1. DEC a=0x01 → y=0x00, zero=1.
- Back-to-back opcodes 0–20, one per clock, a=0x07 b=0x04 → 21 consecutive out_valid pulses. Spot checks:
  - op 7 → y=0x03.
  - op 15 → y=0x03.
  - op 16 → y=0x0E, carry=0.
  - op 20 → y=0x83, carry=1.
- MUL (ALU_MUL_EN) a=0xFF b=0xFF → in_ready low 8 clocks, with in_valid pulsed during that time ignored. out_valid 8 clocks after acceptance with y_hi=0xFE, y=0x01, zero=0.
- Reset asserted 4 clocks into MUL → no out_valid, outputs 0. Then opcode 25 → y=0, err=1. Without ALU_MUL_EN, opcode 21 → 1-cycle result y=0, err=1.
